// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline controller: FSM state encoding,
// the bundled control-output struct and the canned control patterns.
package pipe_ctrl_pkg;

    localparam int DEF_REG_W = 3;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2,
        HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_vld;
        logic idex_vld;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE    = 7'b00000_00;
    localparam ctrl_t CTRL_RUN     = 7'b11111_11;
    localparam ctrl_t CTRL_FLUSH   = 7'b11111_00;
    localparam ctrl_t CTRL_LOADUSE = 7'b00111_10;
    localparam ctrl_t CTRL_IMISS   = 7'b01111_01;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination is read by the decode instruction.
module hazard_detect #(
    parameter int REG_W = 3
) (
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    input  logic             i_id_rs_vld,
    input  logic             i_id_rt_vld,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_memread,
    input  logic             i_ex_regwrite,
    output logic             o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    assign w_rs_hit   = i_id_rs_vld & (i_id_rs == i_ex_rd);
    assign w_rt_hit   = i_id_rt_vld & (i_id_rt == i_ex_rd);
    assign o_load_use = i_ex_memread & i_ex_regwrite & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline stall/flush controller (RUN/IMISS/DMISS/HALT).
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic             br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    input  logic             dmem_done,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_vld,
    output logic             idex_vld,
    output logic             halted,
`ifdef PIPE_CTRL_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic [1:0]       dbg_state,
    output logic             dbg_redir_pend
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_redir_pend;
    logic   w_redir_nxt;
    logic   w_load_use;
    ctrl_t  w_ctrl;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .i_id_rs       (id_rs),
        .i_id_rt       (id_rt),
        .i_id_rs_vld   (id_rs_vld),
        .i_id_rt_vld   (id_rt_vld),
        .i_ex_rd       (ex_rd),
        .i_ex_memread  (ex_memread),
        .i_ex_regwrite (ex_regwrite),
        .o_load_use    (w_load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_redir_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_redir_pend <= w_redir_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_redir_nxt = r_redir_pend;
        if (wb_halt) begin
            w_state_nxt = HALT;
        end else begin
            case (r_state)
                RUN: begin
                    if (dmem_stall)                    w_state_nxt = DMISS;
                    else if (br_taken || w_load_use)   w_state_nxt = RUN;
                    else if (imem_stall)               w_state_nxt = IMISS;
                end
                IMISS: begin
                    if (dmem_stall)                    w_state_nxt = DMISS;
                    else if (!imem_stall)              w_state_nxt = RUN;
                    // A redirect while the fetch is still outstanding poisons that fetch.
                    if (br_taken && imem_stall && !dmem_stall) w_redir_nxt = 1'b1;
                end
                DMISS: begin
                    if (dmem_done)                     w_state_nxt = RUN;
                end
                default: w_state_nxt = HALT;
            endcase
        end
        if (w_state_nxt == RUN || w_state_nxt == HALT) w_redir_nxt = 1'b0;
    end

    always_comb begin
        w_ctrl = CTRL_NONE;
        if (rst_n && !wb_halt) begin
            case (r_state)
                RUN, IMISS: begin
                    if (dmem_stall)        w_ctrl = CTRL_NONE;
                    else if (br_taken)     w_ctrl = CTRL_FLUSH;
                    else if (w_load_use)   w_ctrl = CTRL_LOADUSE;
                    else if (imem_stall)   w_ctrl = CTRL_IMISS;
                    else begin
                        w_ctrl = CTRL_RUN;
                        if (r_state == IMISS && r_redir_pend) w_ctrl.ifid_vld = 1'b0;
                    end
                end
                DMISS: begin
                    if (dmem_done)         w_ctrl = CTRL_RUN;
                end
                default: w_ctrl = CTRL_NONE;
            endcase
        end
    end

    assign pc_en          = w_ctrl.pc_en;
    assign ifid_en        = w_ctrl.ifid_en;
    assign idex_en        = w_ctrl.idex_en;
    assign exmem_en       = w_ctrl.exmem_en;
    assign memwb_en       = w_ctrl.memwb_en;
    assign ifid_vld       = w_ctrl.ifid_vld;
    assign idex_vld       = w_ctrl.idex_vld;
    assign halted         = rst_n & (r_state == HALT);
    assign dbg_state      = r_state;
    assign dbg_redir_pend = r_redir_pend;

`ifdef PIPE_CTRL_PERF_EN
    logic             w_stall_evt;
    logic             w_flush_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // CTRL_FLUSH is only ever selected by a taken branch, so it marks a squash.
    assign w_stall_evt = rst_n & ~wb_halt & (r_state != HALT) & ~w_ctrl.pc_en;
    assign w_flush_evt = rst_n & (w_ctrl == CTRL_FLUSH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt) r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_flush_evt) r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; perf counter checks are built with PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;

    localparam int REG_W = 3;
    localparam int CNT_W = 16;

    // Control vector order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_vld, idex_vld, halted}
    localparam logic [7:0] EXP_RUN    = 8'b1111_1110;
    localparam logic [7:0] EXP_FLUSH  = 8'b1111_1000;
    localparam logic [7:0] EXP_LU     = 8'b0011_1100;
    localparam logic [7:0] EXP_IMISS  = 8'b0111_1010;
    localparam logic [7:0] EXP_DISC   = 8'b1111_1010;
    localparam logic [7:0] EXP_FROZEN = 8'b0000_0000;
    localparam logic [7:0] EXP_HALTED = 8'b0000_0001;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_IMISS = 2'd1;
    localparam logic [1:0] ST_DMISS = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    logic             clk;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_rs_vld, id_rt_vld, ex_memread, ex_regwrite;
    logic             br_taken, imem_stall, dmem_stall, dmem_done, wb_halt;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_vld, idex_vld, halted;
    logic [1:0]       dbg_state;
    logic             dbg_redir_pend;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    logic [7:0] obs;
    assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_vld, idex_vld, halted};

    int n_cmp;
    int n_fail;

    pipe_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_rs_vld      (id_rs_vld),
        .id_rt_vld      (id_rt_vld),
        .ex_rd          (ex_rd),
        .ex_memread     (ex_memread),
        .ex_regwrite    (ex_regwrite),
        .br_taken       (br_taken),
        .imem_stall     (imem_stall),
        .dmem_stall     (dmem_stall),
        .dmem_done      (dmem_done),
        .wb_halt        (wb_halt),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_vld       (ifid_vld),
        .idex_vld       (idex_vld),
        .halted         (halted),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .dbg_state      (dbg_state),
        .dbg_redir_pend (dbg_redir_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at edge+1, outputs are compared at edge+3.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs = '0; id_rt = '0; ex_rd = '0;
        id_rs_vld = 1'b0; id_rt_vld = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0;
        br_taken = 1'b0; imem_stall = 1'b0;
        dmem_stall = 1'b0; dmem_done = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic set_lu(input logic [REG_W-1:0] rs, input logic rs_v,
                          input logic [REG_W-1:0] rt, input logic rt_v,
                          input logic [REG_W-1:0] rd, input logic mr, input logic rw);
        id_rs = rs; id_rs_vld = rs_v; id_rt = rt; id_rt_vld = rt_v;
        ex_rd = rd; ex_memread = mr; ex_regwrite = rw;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_in();
        br_taken = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_FROZEN) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, EXP_FROZEN); end
        tick();
        tick();
        n_cmp++;
        if (dbg_state !== ST_RUN || dbg_redir_pend !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got %0d/%b want %0d/0", dbg_state, dbg_redir_pend, ST_RUN);
        end
        rst_n = 1'b1;
        idle_in();
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL reset_release: got %b want %b", obs, EXP_RUN); end
        tick();
    endtask

    task automatic test_load_use();
        set_lu(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (obs !== EXP_LU) begin n_fail++; $display("FAIL load_use_rs: got %b want %b", obs, EXP_LU); end
        tick();
        set_lu(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 1'b0);
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL load_use_one_bubble: got %b st %0d want %b st 0", obs, dbg_state, EXP_RUN);
        end
        tick();
        set_lu(3'd2, 1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (obs !== EXP_LU) begin n_fail++; $display("FAIL load_use_rt: got %b want %b", obs, EXP_LU); end
        tick();
        set_lu(3'd3, 1'b0, 3'd0, 1'b1, 3'd3, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL load_use_rs_not_read: got %b want %b", obs, EXP_RUN); end
        tick();
        set_lu(3'd4, 1'b1, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL load_use_no_regwrite: got %b want %b", obs, EXP_RUN); end
        tick();
        set_lu(3'd6, 1'b1, 3'd0, 1'b0, 3'd6, 1'b0, 1'b1);
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL load_use_not_load: got %b want %b", obs, EXP_RUN); end
        tick();
        set_lu(3'd7, 1'b1, 3'd7, 1'b1, 3'd6, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL load_use_other_reg: got %b want %b", obs, EXP_RUN); end
        tick();
        idle_in();
    endtask

    task automatic test_branch();
        br_taken = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_FLUSH) begin n_fail++; $display("FAIL branch_flush: got %b want %b", obs, EXP_FLUSH); end
        tick();
        br_taken = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL branch_after: got %b st %0d want %b st 0", obs, dbg_state, EXP_RUN);
        end
        tick();
    endtask

    task automatic test_priority();
        br_taken = 1'b1;
        set_lu(3'd2, 1'b1, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        #2;
        n_cmp++;
        if (obs !== EXP_FLUSH) begin n_fail++; $display("FAIL prio_branch_over_lu: got %b want %b", obs, EXP_FLUSH); end
        tick();
        br_taken = 1'b0;
        imem_stall = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_LU) begin n_fail++; $display("FAIL prio_lu_over_imiss: got %b want %b", obs, EXP_LU); end
        tick();
        n_cmp++;
        if (dbg_state !== ST_RUN) begin n_fail++; $display("FAIL prio_lu_stays_run: got %0d want %0d", dbg_state, ST_RUN); end
        idle_in();
        dmem_stall = 1'b1;
        br_taken = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_FROZEN) begin n_fail++; $display("FAIL prio_dmiss_over_branch: got %b want %b", obs, EXP_FROZEN); end
        tick();
        dmem_stall = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_FROZEN || dbg_state !== ST_DMISS) begin
            n_fail++; $display("FAIL prio_dmiss_hold: got %b st %0d want %b st 2", obs, dbg_state, EXP_FROZEN);
        end
        tick();
        dmem_done = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL prio_dmiss_done: got %b want %b", obs, EXP_RUN); end
        tick();
        dmem_done = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_FLUSH || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL prio_branch_after_dmiss: got %b st %0d want %b st 0", obs, dbg_state, EXP_FLUSH);
        end
        tick();
        idle_in();
    endtask

    task automatic test_dmiss();
        dmem_stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            n_cmp++;
            if (obs !== EXP_FROZEN) begin n_fail++; $display("FAIL dmiss_frozen_c%0d: got %b want %b", c, obs, EXP_FROZEN); end
            tick();
            dmem_stall = 1'b0;
        end
        dmem_done = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_state !== ST_DMISS) begin
            n_fail++; $display("FAIL dmiss_done: got %b st %0d want %b st 2", obs, dbg_state, EXP_RUN);
        end
        tick();
        dmem_done = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL dmiss_exit: got %b st %0d want %b st 0", obs, dbg_state, EXP_RUN);
        end
        tick();
    endtask

    task automatic test_imiss();
        imem_stall = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_IMISS) begin n_fail++; $display("FAIL imiss_c1: got %b want %b", obs, EXP_IMISS); end
        tick();
        br_taken = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_FLUSH || dbg_state !== ST_IMISS) begin
            n_fail++; $display("FAIL imiss_c2_branch: got %b st %0d want %b st 1", obs, dbg_state, EXP_FLUSH);
        end
        tick();
        br_taken = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_IMISS || dbg_redir_pend !== 1'b1) begin
            n_fail++; $display("FAIL imiss_c3_pend: got %b pend %b want %b pend 1", obs, dbg_redir_pend, EXP_IMISS);
        end
        tick();
        imem_stall = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_DISC) begin n_fail++; $display("FAIL imiss_exit_discard: got %b want %b", obs, EXP_DISC); end
        tick();
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_redir_pend !== 1'b0 || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL imiss_after: got %b pend %b st %0d want %b pend 0 st 0", obs, dbg_redir_pend, dbg_state, EXP_RUN);
        end
        tick();
        imem_stall = 1'b1;
        tick();
        imem_stall = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN) begin n_fail++; $display("FAIL imiss_plain_exit: got %b want %b", obs, EXP_RUN); end
        tick();
    endtask

    task automatic test_reset_mid_dmiss();
        dmem_stall = 1'b1;
        tick();
        dmem_stall = 1'b0;
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_FROZEN) begin n_fail++; $display("FAIL rst_dmiss_outputs: got %b want %b", obs, EXP_FROZEN); end
        tick();
        rst_n = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL rst_dmiss_release: got %b st %0d want %b st 0", obs, dbg_state, EXP_RUN);
        end
        tick();
    endtask

    task automatic test_halt();
        wb_halt = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_FROZEN) begin n_fail++; $display("FAIL halt_entry: got %b want %b", obs, EXP_FROZEN); end
        tick();
        wb_halt = 1'b0;
        br_taken = 1'b1;
        imem_stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_cmp++;
            if (obs !== EXP_HALTED || dbg_state !== ST_HALT) begin
                n_fail++; $display("FAIL halt_sticky_c%0d: got %b st %0d want %b st 3", c, obs, dbg_state, EXP_HALTED);
            end
            tick();
        end
        idle_in();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_FROZEN) begin n_fail++; $display("FAIL halt_reset: got %b want %b", obs, EXP_FROZEN); end
        tick();
        rst_n = 1'b1;
        #2;
        n_cmp++;
        if (obs !== EXP_RUN || dbg_state !== ST_RUN) begin
            n_fail++; $display("FAIL halt_restored: got %b st %0d want %b st 0", obs, dbg_state, EXP_RUN);
        end
        tick();
        dmem_stall = 1'b1;
        tick();
        dmem_stall = 1'b0;
        wb_halt = 1'b1;
        tick();
        wb_halt = 1'b0;
        #2;
        n_cmp++;
        if (obs !== EXP_HALTED) begin n_fail++; $display("FAIL halt_from_dmiss: got %b want %b", obs, EXP_HALTED); end
        do_reset();
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_perf();
        do_reset();
        #2;
        n_cmp++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            n_fail++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            set_lu(3'(i), 1'b1, 3'd0, 1'b0, 3'(i), 1'b1, 1'b1);
            tick();
            idle_in();
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            br_taken = 1'b1;
            tick();
            br_taken = 1'b0;
            tick();
        end
        #2;
        n_cmp++;
        if (stall_cnt !== 16'd5 || flush_cnt !== 16'd2) begin
            n_fail++; $display("FAIL perf_counts: got %0d/%0d want 5/2", stall_cnt, flush_cnt);
        end
        imem_stall = 1'b1;
        for (int i = 0; i < 65530; i++) tick();
        imem_stall = 1'b0;
        tick();
        #2;
        n_cmp++;
        if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL perf_max: got %h want ffff", stall_cnt); end
        set_lu(3'd1, 1'b1, 3'd0, 1'b0, 3'd1, 1'b1, 1'b1);
        tick();
        idle_in();
        #2;
        n_cmp++;
        if (stall_cnt !== 16'h0000) begin n_fail++; $display("FAIL perf_wrap: got %h want 0000", stall_cnt); end
        tick();
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle_in();
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_priority();
        test_dmiss();
        test_imiss();
        test_reset_mid_dmiss();
        test_halt();
`ifdef PIPE_CTRL_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 3: register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 16: performance-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous reset, active-low.
REQ-005 SHALL have ports id_rs/id_rt, input, REG_W each: source registers of the decode instruction.
REQ-006 SHALL have ports id_rs_vld/id_rt_vld, input, 1 each: each source is actually read.
REQ-007 SHALL have ports ex_rd, input, REG_W; ex_memread and ex_regwrite, input, 1 each: EX-stage destination and load flag.
REQ-008 SHALL have port br_taken, input, 1: taken branch or jump resolved in EX.
REQ-009 SHALL have ports imem_stall, dmem_stall and dmem_done, input, 1 each: cache handshakes.
REQ-010 SHALL have port wb_halt, input, 1: a HALT instruction is in WB.
REQ-011 SHALL have ports pc_en, ifid_en, idex_en, exmem_en and memwb_en, output, 1 each: pipeline-register enables.
REQ-012 SHALL have ports ifid_vld and idex_vld, output, 1 each: 0 inserts a NOP or bubble.
REQ-013 SHALL have port halted, output, 1: sticky halt indication.

Function
REQ-014 SHALL implement FSM states RUN, IMISS, DMISS and HALT.
REQ-015 Outputs SHALL be combinational from state, flops and inputs.
REQ-016 Hazard priority, highest first, SHALL be: HALT > dmem miss > branch flush > load-use > imem miss.
REQ-017 RUN with no hazard: all enables 1, ifid_vld=1, idex_vld=1.
REQ-018 Load-use SHALL be detected as ex_memread & ex_regwrite & ((id_rs_vld & id_rs==ex_rd) | (id_rt_vld & id_rt==ex_rd)).
REQ-019 On load-use: pc_en=0, ifid_en=0, idex_vld=0, all other enables 1; exactly one bubble.
REQ-020 On br_taken in RUN: all enables 1, ifid_vld=0, idex_vld=0; two slots squashed.
REQ-021 On dmem_stall in RUN or IMISS: next state DMISS; in that cycle and all DMISS cycles every enable SHALL be 0.
REQ-022 DMISS SHALL exit to RUN on the dmem_done cycle; that cycle all enables SHALL be 1.
REQ-023 DMISS SHALL freeze EX, so a pending br_taken or load-use is evaluated again in RUN after exit.
REQ-024 On imem_stall in RUN (no higher hazard): next state IMISS; pc_en=0 and ifid_vld=0; the rest advance.
REQ-025 IMISS SHALL return to RUN on the first cycle imem_stall=0.
REQ-026 br_taken during IMISS SHALL set flop redir_pend and squash as in REQ-020.
REQ-027 While redir_pend=1, the fetch completing on IMISS exit SHALL be discarded (ifid_vld=0); redir_pend then clears.
REQ-028 wb_halt=1 SHALL enter HALT from any state; in HALT all enables 0 and halted=1 until reset.
REQ-029 Simultaneous dmem_stall and br_taken SHALL freeze; the branch is applied after dmem_done.
REQ-030 Load-use with imem_stall: load-use outputs SHALL win; state stays RUN.

Reset
REQ-031 While rst_n=0: state=RUN, redir_pend=0, halted=0, all enables 0, ifid_vld=0, idex_vld=0.
REQ-032 Reset SHALL override every state, including mid-DMISS; the first cycle after release follows REQ-017.

Configuration
REQ-033 With PIPE_CTRL_PERF_EN defined: outputs stall_cnt[CNT_W] (cycles with pc_en=0, excluding HALT) and flush_cnt[CNT_W] (br_taken squashes) SHALL exist, wrap at 2^CNT_W-1 to 0, and reset to 0.
REQ-034 Without PIPE_CTRL_PERF_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Structure
REQ-035 Package pipe_ctrl_pkg SHALL hold the state typedef (RUN, IMISS, DMISS, HALT) and default REG_W and CNT_W.
REQ-036 The REQ-018 comparison SHALL be a combinational sub-module hazard_detect.

Verification
REQ-037 Load r1 in EX, add reading r1 in ID -> exactly one cycle with pc_en=0, ifid_en=0, idex_vld=0.
REQ-038 br_taken=1 for 1 cycle -> ifid_vld=0 and idex_vld=0 that cycle; enables stay 1.
REQ-039 dmem_stall for 1 cycle, dmem_done 4 cycles later -> all enables 0 for 4 cycles, 1 on the done cycle.
REQ-040 imem_stall for 3 cycles with br_taken in cycle 2 -> fetch returned on exit discarded (ifid_vld=0); redir_pend back to 0.
REQ-041 wb_halt=1 -> halted=1 and all enables 0 indefinitely; rst_n=0 for 1 cycle -> RUN restored.
REQ-042 PERF build: 5 load-use stalls and 2 flushes -> stall_cnt=5, flush_cnt=2; preset to 0xFFFF then one stall -> 0.
